// File: rtl/store_pkg.sv
// Shared store-path definitions: size codes, controller states and the
// alignment/lane helpers used by the narrowing store and the load extender.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } state_e;

  // True when the request must be rejected without touching memory.
  function automatic logic is_bad_store(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte lanes written by a store; the big-endian layout is the bit-mirror.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo,
                                           input logic little_end);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << addr_lo;
      SZ_HALF: m = addr_lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return little_end ? m : {m[0], m[1], m[2], m[3]};
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational merge of narrowed store data into the word read back from memory.
module store_lane_merge
  import store_pkg::*;
#(
  parameter int LITTLE_END = 1
) (
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  output logic [31:0] merged_word
);

  logic [3:0]  mask;
  logic [31:0] rep;

  // Replicate the narrow value across all lanes, then keep only the addressed ones.
  always_comb begin
    mask = lane_mask(size, addr_lo, (LITTLE_END != 0));
    case (size)
      SZ_BYTE: rep = {4{new_data[7:0]}};
      SZ_HALF: rep = {2{new_data[15:0]}};
      default: rep = new_data;
    endcase
    merged_word = old_word;
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) begin
        merged_word[8*k +: 8] = rep[8*k +: 8];
      end else begin
        merged_word[8*k +: 8] = old_word[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/store_narrow_rmw.sv
// Narrowing store unit: sub-word stores become read-modify-write on a word-wide
// memory without byte enables; word stores write directly.
module store_narrow_rmw
  import store_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LITTLE_END = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic              mem_rd_valid,
  input  logic [31:0]       mem_rd_data,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wr_data,
  input  logic              mem_wr_ready,
  output logic              done,
  output logic              err
);

  state_e      state_r, state_nx;
  logic [1:0]  size_r;
  logic [1:0]  addr_lo_r;
  logic [31:0] data_r;
  logic [31:0] merged_s;
  logic        accept_s;
  logic        bad_s;
  logic        err_nx_s;

  store_lane_merge #(.LITTLE_END(LITTLE_END)) u_merge (
    .old_word    (mem_rd_data),
    .new_data    (data_r),
    .size        (size_r),
    .addr_lo     (addr_lo_r),
    .merged_word (merged_s)
  );

  // Next-state logic; err is decided only on the IDLE->RESP rejection path.
  always_comb begin
    accept_s = req_valid && (state_r == IDLE);
    bad_s    = is_bad_store(req_size, req_addr[1:0]);
    err_nx_s = 1'b0;
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (bad_s) begin
            state_nx = RESP;
            err_nx_s = 1'b1;
          end else if (req_size == SZ_WORD) begin
            state_nx = WR;
          end else begin
            state_nx = RD_REQ;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      RD_REQ:  state_nx = RD_WAIT;
      RD_WAIT: begin
        if (mem_rd_valid) begin
          state_nx = WR;
        end else begin
          state_nx = RD_WAIT;
        end
      end
      WR: begin
        if (mem_wr_ready) begin
          state_nx = RESP;
        end else begin
          state_nx = WR;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Request capture; later req_* activity cannot disturb an operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_r    <= 2'b00;
      addr_lo_r <= 2'b00;
      data_r    <= 32'h0000_0000;
    end else if (accept_s) begin
      size_r    <= req_size;
      addr_lo_r <= req_addr[1:0];
      data_r    <= req_data;
    end
  end

  // Registered outputs, decoded from the next state so they line up with state_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready   <= 1'b1;
      mem_rd_en   <= 1'b0;
      mem_wr_en   <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= 32'h0000_0000;
    end else begin
      req_ready <= (state_nx == IDLE);
      mem_rd_en <= (state_nx == RD_REQ);
      mem_wr_en <= (state_nx == WR);
      done      <= (state_nx == RESP);
      err       <= err_nx_s;
      if (accept_s && !bad_s) begin
        mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
      end
      if (accept_s && !bad_s && (req_size == SZ_WORD)) begin
        mem_wr_data <= req_data;
      end else if ((state_r == RD_WAIT) && mem_rd_valid) begin
        mem_wr_data <= merged_s;
      end
    end
  end

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Directed bench for store_narrow_rmw with a small word memory model that has
// configurable read latency and write backpressure.
module tb_store_narrow_rmw;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic        mem_rd_valid = 1'b0;
  logic [31:0] mem_rd_data = 32'h0;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ready;
  logic        done;
  logic        err;

  logic [31:0] mem [0:255];
  logic        ld_en = 1'b0;
  logic [7:0]  ld_idx = 8'd0;
  logic [31:0] ld_val = 32'h0;
  logic [31:0] rd_addr_q = 32'h0;
  int          rd_lat = 1;
  int          stall_cfg = 0;
  int          rd_cnt = 0;
  int          wr_wait = 0;
  int          wr_cnt = 0;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  store_narrow_rmw #(.ADDR_W(32), .LITTLE_END(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_size(req_size),
    .req_addr(req_addr), .req_data(req_data),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_valid(mem_rd_valid),
    .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .mem_wr_ready(mem_wr_ready), .done(done), .err(err)
  );

  assign mem_wr_ready = (wr_wait >= stall_cfg);

  // Memory model: read answers rd_lat cycles after the strobe; write stalls stall_cfg cycles.
  always @(posedge clk) begin
    mem_rd_valid <= 1'b0;
    if (ld_en) mem[ld_idx] <= ld_val;
    if (mem_rd_en) begin
      rd_addr_q <= mem_addr;
      if (rd_lat <= 1) begin
        mem_rd_valid <= 1'b1;
        mem_rd_data  <= mem[mem_addr[9:2]];
        rd_cnt       <= 0;
      end else begin
        rd_cnt <= rd_lat - 1;
      end
    end else if (rd_cnt != 0) begin
      rd_cnt <= rd_cnt - 1;
      if (rd_cnt == 1) begin
        mem_rd_valid <= 1'b1;
        mem_rd_data  <= mem[rd_addr_q[9:2]];
      end
    end
    if (mem_wr_en) wr_wait <= wr_wait + 1;
    else           wr_wait <= 0;
    if (mem_wr_en && mem_wr_ready) begin
      mem[mem_addr[9:2]] <= mem_wr_data;
      wr_cnt  <= wr_cnt + 1;
      wr_wait <= 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    ld_idx = idx;
    ld_val = val;
    ld_en  = 1'b1;
    @(posedge clk); #1;
    ld_en  = 1'b0;
  endtask

  // Issue one request in the current cycle (T) and observe it until done.
  task automatic run_and_check(input string tag, input logic [1:0] sz, input logic [31:0] a,
                               input logic [31:0] d, input logic [31:0] exp_wa,
                               input logic [31:0] exp_wd, input int exp_lat, input logic exp_e,
                               input int exp_rd, input int exp_nwr, input int exp_first_wr);
    int          lat, n_rd, n_wr, first_wr;
    logic        e, stable, rdy;
    logic [31:0] rd_a;
    req_valid = 1'b1; req_size = sz; req_addr = a; req_data = d;
    @(posedge clk); #1;
    req_valid = 1'b0; req_size = 2'b11; req_addr = 32'hFFFF_FFFF; req_data = 32'h0BAD_0BAD;
    lat = 0; n_rd = 0; n_wr = 0; first_wr = 0; e = 1'b0; stable = 1'b1; rdy = 1'b1; rd_a = 32'h0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mem_rd_en) begin n_rd++; rd_a = mem_addr; end
      if (mem_wr_en) begin
        n_wr++;
        if (first_wr == 0) first_wr = k;
        if (mem_addr !== exp_wa || mem_wr_data !== exp_wd) stable = 1'b0;
      end
      if (done) begin lat = k; e = err; rdy = req_ready; break; end
    end
    check_eq({tag, ".lat"}, lat, exp_lat);
    check_eq({tag, ".err"}, {31'd0, e}, {31'd0, exp_e});
    check_eq({tag, ".n_rd"}, n_rd, exp_rd);
    check_eq({tag, ".n_wr"}, n_wr, exp_nwr);
    check_eq({tag, ".ready_in_resp"}, {31'd0, rdy}, 32'd0);
    if (exp_rd > 0) check_eq({tag, ".rd_addr"}, rd_a, exp_wa);
    if (exp_nwr > 0) begin
      check_eq({tag, ".wr_stable"}, {31'd0, stable}, 32'd1);
      check_eq({tag, ".first_wr"}, first_wr, exp_first_wr);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int wcnt0;
    rst_n = 1'b0; req_valid = 1'b0; req_size = 2'b00; req_addr = 32'h0; req_data = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst.req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst.rd_en", {31'd0, mem_rd_en}, 32'd0);
    check_eq("rst.wr_en", {31'd0, mem_wr_en}, 32'd0);
    check_eq("rst.done", {31'd0, done}, 32'd0);
    check_eq("rst.err", {31'd0, err}, 32'd0);
    check_eq("rst.mem_addr", mem_addr, 32'h0);
    check_eq("rst.wr_data", mem_wr_data, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    preload(8'd64, 32'h1122_3344);
    run_and_check("sb101", 2'b00, 32'h101, 32'hFFFF_FFAB, 32'h100, 32'h1122_AB44, 4, 1'b0, 1, 1, 3);
    check_eq("sb101.mem", mem[64], 32'h1122_AB44);

    preload(8'd64, 32'h1122_3344);
    run_and_check("sh102", 2'b01, 32'h102, 32'h0000_BEEF, 32'h100, 32'hBEEF_3344, 4, 1'b0, 1, 1, 3);
    check_eq("sh102.mem", mem[64], 32'hBEEF_3344);

    preload(8'd64, 32'h1122_3344);
    run_and_check("sh100", 2'b01, 32'h100, 32'h0000_BEEF, 32'h100, 32'h1122_BEEF, 4, 1'b0, 1, 1, 3);
    check_eq("sh100.mem", mem[64], 32'h1122_BEEF);

    run_and_check("sw104", 2'b10, 32'h104, 32'hDEAD_BEEF, 32'h104, 32'hDEAD_BEEF, 2, 1'b0, 0, 1, 1);
    check_eq("sw104.mem", mem[65], 32'hDEAD_BEEF);

    preload(8'd64, 32'h1122_3344);
    run_and_check("sh103", 2'b01, 32'h103, 32'h0000_1234, 32'h0, 32'h0, 1, 1'b1, 0, 0, 0);
    run_and_check("sw106", 2'b10, 32'h106, 32'h1234_5678, 32'h0, 32'h0, 1, 1'b1, 0, 0, 0);
    run_and_check("sz11", 2'b11, 32'h100, 32'h1234_5678, 32'h0, 32'h0, 1, 1'b1, 0, 0, 0);
    check_eq("err.mem", mem[64], 32'h1122_3344);

    rd_lat = 2; stall_cfg = 3;
    run_and_check("stall", 2'b00, 32'h100, 32'h0000_0055, 32'h100, 32'h1122_3355, 8, 1'b0, 1, 4, 4);
    check_eq("stall.mem", mem[64], 32'h1122_3355);
    rd_lat = 1; stall_cfg = 0;

    // Reset while the read is outstanding: nothing may be written afterwards.
    preload(8'd64, 32'h1122_3344);
    rd_lat = 5;
    wcnt0 = wr_cnt;
    req_valid = 1'b1; req_size = 2'b00; req_addr = 32'h100; req_data = 32'h0000_0077;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_eq("mid.req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("mid.rd_en", {31'd0, mem_rd_en}, 32'd0);
    check_eq("mid.wr_en", {31'd0, mem_wr_en}, 32'd0);
    check_eq("mid.mem_addr", mem_addr, 32'h0);
    check_eq("mid.wr_data", mem_wr_data, 32'h0);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("mid.ready_after", {31'd0, req_ready}, 32'd1);
    check_eq("mid.wr_en_after", {31'd0, mem_wr_en}, 32'd0);
    check_eq("mid.wr_cnt", wr_cnt, wcnt0);
    check_eq("mid.mem", mem[64], 32'h1122_3344);
    rd_lat = 1;
    @(posedge clk); #1;

    run_and_check("sb103", 2'b00, 32'h103, 32'h0000_00CC, 32'h100, 32'hCC22_3344, 4, 1'b0, 1, 1, 3);
    check_eq("sb103.mem", mem[64], 32'hCC22_3344);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/store_narrow_rmw.md
Name: store_narrow_rmw

Overview:
Store-side counterpart of the load-path sign extender. It takes a 32-bit register value plus a size code (byte, halfword or word) and narrows it to the addressed byte lanes. Stores go to a word-wide data memory that has no byte enables, so sub-word stores use a read-modify-write sequence. The block sits between the datapath store issue and the data memory, and returns a one-cycle done/err response per request.

Parameters:
- ADDR_W, 32, byte-address width of req_addr and mem_addr.
- LITTLE_END, 1, lane order. 1 places byte k at bits [8k+7:8k]; 0 mirrors the lanes (byte k at [31-8k:24-8k]).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  store request present.
- req_ready  out  1  block can accept a request (IDLE only).
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_addr  in  ADDR_W  byte address.
- req_data  in  32  register value; the low bits are used for sub-word stores.
- mem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0).
- mem_rd_en  out  1  one-cycle read strobe.
- mem_rd_valid  in  1  read data valid, at least 1 cycle after mem_rd_en.
- mem_rd_data  in  32  read word.
- mem_wr_en  out  1  write request, held until accepted.
- mem_wr_data  out  32  merged write word.
- mem_wr_ready  in  1  memory accepts the write this cycle.
- done  out  1  one-cycle completion pulse.
- err  out  1  qualifies done: request rejected, no memory access performed.

Behaviour:
- Reset values: state IDLE; req_ready=1; mem_rd_en=0; mem_wr_en=0; done=0; err=0; mem_addr=0; mem_wr_data=0.
- Handshake: a request is accepted when req_valid && req_ready. On acceptance, addr, size and data are registered. Later changes on the req_* inputs have no effect.
- Alignment check at accept:
  - A halfword with addr[0]=1 is misaligned.
  - A word with addr[1:0]!=0 is misaligned.
  - size=11 is illegal.
  - Any of these goes to RESP with err=1, and no mem strobes are issued.
- States:
  - IDLE: req_ready=1. On accept: word store goes to WR; byte or half store goes to RD_REQ; error goes to RESP.
  - RD_REQ: mem_rd_en=1 for exactly one cycle, mem_addr={addr[ADDR_W-1:2],2'b00}. Goes to RD_WAIT.
  - RD_WAIT: waits for mem_rd_valid, then captures the merged word into the write-data register and goes to WR.
  - WR: mem_wr_en=1. mem_addr and mem_wr_data stay stable until mem_wr_ready. On ready, goes to RESP.
  - RESP: done=1 (err as flagged) for one cycle, then IDLE.
- Merge rule (LITTLE_END=1):
  - Byte: lane addr[1:0] is replaced by req_data[7:0]; the other three bytes come from mem_rd_data.
  - Half: lanes {addr[1],1} and {addr[1],0} are replaced by req_data[15:0]; the other half comes from mem_rd_data.
  - Word: mem_wr_data = req_data. No read is performed.
- Latency, with acceptance in cycle T and memory responding as early as allowed:
  - Word: WR at T+1, done at T+2.
  - Byte/half: RD_REQ at T+1, rd_valid at T+2, WR at T+3, done at T+4.
  - Error: done at T+1.
- Backpressure: each cycle mem_wr_ready is low extends WR by one cycle. Each extra cycle of read latency extends RD_WAIT by one cycle.
- mem_rd_valid outside RD_WAIT is ignored.
- mem_wr_ready outside WR is ignored.
- No new request is accepted during RESP; req_ready returns in the following IDLE cycle.
- Reset mid-operation: immediate return to IDLE with all strobes low. A partially completed RMW is abandoned; no write is issued after reset.

Decomposition:
- Shared package store_pkg:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL.
  - State enum {IDLE, RD_REQ, RD_WAIT, WR, RESP}.
  - Misalign-check function.
- The load sign extender later uses the same size codes from this package.
- Sub-module store_lane_merge: purely combinational (old_word, new_data, size, addr[1:0] → merged_word). It is verified standalone.

Test Plan:
- The memory model word at 0x100 holds 0x11223344. SB addr 0x101, data 0xFFFFFFAB → one mem_rd_en at 0x100, then write 0x1122AB44 to 0x100, done at T+4, err=0.
- SH addr 0x102, data 0x0000BEEF on the same initial word → write 0xBEEF3344. SH addr 0x100 → write 0x1122BEEF.
- SW addr 0x104, data 0xDEADBEEF → mem_rd_en never asserted, mem_wr_en at T+1 with 0xDEADBEEF, done at T+2.
- SH addr 0x103 → done+err at T+1. The same holds for SW addr 0x106 and for size=11. mem_rd_en and mem_wr_en stay 0 throughout.
- SB addr 0x100, data 0x55 with mem_wr_ready held low for 3 cycles and read latency of 2 cycles → mem_wr_en, mem_addr=0x100 and mem_wr_data=0x11223355 are held stable, and done arrives at T+8.
- SB in flight: rst_n asserted during RD_WAIT → outputs return to reset values asynchronously, no mem_wr_en occurs, and the memory word is unchanged. After release, req_ready=1.
